bit_packer: RTL and testbench
=============================

// Module: bit_packer
// PURPOSE
//  Parametrised MSB-first packer that appends variable-length codes (0..MAX_CODE_W bits) into OUT_W-bit words.
//  Sits between the entropy coder and the slice byte-stream writer.
//  Adds valid/ready backpressure on both sides, masking of unused code bits, and flush with zero pad to a byte boundary.
//  Emits a byte count and last flag on the final partial word.
// PARAMETERS
//  OUT_W       32  output word width in bits; multiple of 8, >= 8
//  MAX_CODE_W  32  max code length per input beat; <= OUT_W
// PORTS
//  clock      in   1                      rising-edge clock
//  reset_n    in   1                      asynchronous active-low reset
//  in_valid   in   1                      input beat valid
//  in_ready   out  1                      packer accepts beat this cycle
//  in_val     in   MAX_CODE_W             code, right-justified; bits >= in_len ignored
//  in_len     in   $clog2(MAX_CODE_W+1)   code length, 0..MAX_CODE_W
//  in_flush   in   1                      sideband on beat: append code, then drain and pad
//  out_valid  out  1                      output word valid
//  out_ready  in   1                      consumer takes word
//  out_data   out  OUT_W                  packed bits, first bit at MSB; pad bits zero
//  out_bytes  out  $clog2(OUT_W/8+1)      valid bytes from MSB: OUT_W/8 for full words, 0..OUT_W/8 on last
//  out_last   out  1                      final word of a flushed stream
//  fill_level out  $clog2(OUT_W+MAX_CODE_W+1)  bits held in accumulator (debug)
// BEHAVIOUR
//  Reset (async): acc=0, fill=0, state=RUN.
//    Outputs: out_valid=0, out_data=0, out_bytes=0, out_last=0, in_ready=0 during reset then per rule.
//  Accumulator: ACC_W=OUT_W+MAX_CODE_W bits.
//    New code is masked to in_len LSBs and placed at bit position ACC_W-fill-in_len.
//  Beat acceptance: in_ready = (state==RUN) && (fill < OUT_W); accept = in_valid && in_ready.
//  Word emit:
//    Condition: fill >= OUT_W && (!out_valid || out_ready).
//    Top OUT_W bits move to the output register; acc shifts left OUT_W; out_bytes=OUT_W/8.
//    Latency: a beat completing a word gives out_valid on the next cycle.
//  Same-cycle accept + emit is legal: fill_next = fill - OUT_W + in_len.
//  Output register holds data stable while out_valid && !out_ready; out_valid drops after a take with nothing pending.
//  in_len=0: beat accepted, no bit change. A flush still applies.
//  States:
//    RUN: normal packing. An accepted beat with in_flush=1 goes to FLUSH.
//    FLUSH: in_ready=0; full words drain as above.
//      When fill < OUT_W and the output is free, emit the residue zero-padded.
//      Padded residue: out_bytes = ceil(fill/8), out_last=1; then fill=0 and state goes to RUN.
//      If residue=0 and the flush drained >=1 full word, that last full word carries out_last=1; no extra beat.
//      If residue=0 and nothing was drained, emit one beat with out_bytes=0, out_last=1, out_data=0.
//  out_last and out_bytes are valid only with out_valid. out_last=0 on all non-final words.
//  Backpressure never loses or reorders bits. Accumulator overflow is impossible by the in_ready rule.
//  Reset mid-stream discards the accumulator and any pending output word.
// STRUCTURE
//  Shared package bitstream_pkg:
//    default OUT_W/MAX_CODE_W constants
//    width helper function (clog2-based length/count widths)
//    state enum {RUN, FLUSH}
//  One sub-module, bit_packer_out_reg: output holding register with valid/ready, data/bytes/last.
//  Top holds the accumulator, fill counter, mask/shift datapath and FSM.
// TESTING (OUT_W=32, MAX_CODE_W=32 unless noted)
//  1. Codes (3'b101,3), (5'b00110,5), out_ready=1, then a flush beat with len 0
//     -> one word 0xA6000000, out_bytes=1, out_last=1.
//  2. Four beats (0xFF,8),(0x00,8),(0xAA,8),(0x55,8)
//     -> word 0xFF00AA55, out_bytes=4, out_last=0, on the cycle after the 4th beat.
//  3. Beat (0xFFFFFFFF,32) at fill=7, then flush
//     -> word 0x01FFFFFF (bytes=4, last=0), then 0xFE000000 (bytes=1, last=1).
//  4. out_ready=0 for 10 cycles while streaming (0x1,1) beats
//     -> out_data stable, in_ready drops at fill=32, no bit loss once released.
//  5. in_val=0xFFFFFFFF, in_len=4, then flush
//     -> 0xF0000000, bytes=1: unused bits masked.
//  6. Assert reset_n=0 mid-FLUSH with out_valid=1
//     -> out_valid=0 and fill_level=0 immediately (async); next stream packs from bit 31.

Source files
------------

// File: rtl/bitstream_pkg.sv
// Shared constants, width helper and FSM state type for the bitstream packing blocks.
package bitstream_pkg;

  localparam int DEF_OUT_W      = 32;
  localparam int DEF_MAX_CODE_W = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pack_state_t;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bit_packer_out_reg.sv
// Output holding register: captures one word with its byte count and last flag,
// holds it stable until the consumer takes it.
module bit_packer_out_reg #(
  parameter int DATA_W  = 32,
  parameter int BYTES_W = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DATA_W-1:0]  load_data,
  input  logic [BYTES_W-1:0] load_bytes,
  input  logic               load_last,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [BYTES_W-1:0] out_bytes,
  output logic               out_last,
  output logic               free
);

  assign free = !out_valid || out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bytes <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_bytes <= load_bytes;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_packer.sv
// MSB-first variable-length code packer into OUT_W-bit words, with flush that
// zero-pads the residue to a byte boundary and tags the final word.
module bit_packer
  import bitstream_pkg::*;
#(
  parameter int  OUT_W      = DEF_OUT_W,
  parameter int  MAX_CODE_W = DEF_MAX_CODE_W,
  localparam int LEN_W      = cnt_w(MAX_CODE_W),
  localparam int BYTES_W    = cnt_w(OUT_W / 8),
  localparam int ACC_W      = OUT_W + MAX_CODE_W,
  localparam int FILL_W     = cnt_w(ACC_W)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAX_CODE_W-1:0] in_val,
  input  logic [LEN_W-1:0]      in_len,
  input  logic                  in_flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [BYTES_W-1:0]    out_bytes,
  output logic                  out_last,
  output logic [FILL_W-1:0]     fill_level
);

  pack_state_t         state, state_nxt;
  logic [ACC_W-1:0]    acc, acc_nxt, base_acc;
  logic [FILL_W-1:0]   fill, fill_nxt, base_fill;
  logic                out_free, load, load_last, accept, full_word;
  logic [OUT_W-1:0]    load_data;
  logic [BYTES_W-1:0]  load_bytes;
  logic [MAX_CODE_W-1:0] code_mask;
  logic [ACC_W-1:0]    code_ext, code_top;

  assign in_ready   = reset_n && (state == RUN) && (fill < FILL_W'(OUT_W));
  assign accept     = in_valid && in_ready;
  assign full_word  = fill >= FILL_W'(OUT_W);
  assign fill_level = fill;

  // Left-justify the masked code in the accumulator; it is then shifted down by fill.
  assign code_mask = ~({MAX_CODE_W{1'b1}} << in_len);
  assign code_ext  = ACC_W'(in_val & code_mask);
  assign code_top  = code_ext << (FILL_W'(ACC_W) - FILL_W'(in_len));

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    load_data  = acc[ACC_W-1 -: OUT_W];
    load_bytes = BYTES_W'(OUT_W / 8);
    load_last  = 1'b0;
    base_acc   = acc;
    base_fill  = fill;
    if (out_free && full_word) begin
      load      = 1'b1;
      base_acc  = acc << OUT_W;
      base_fill = fill - FILL_W'(OUT_W);
      // An exact word boundary at the end of a flush: this word is the last one.
      if (state == FLUSH && fill == FILL_W'(OUT_W)) begin
        load_last = 1'b1;
        state_nxt = RUN;
      end
    end else if (out_free && state == FLUSH) begin
      load       = 1'b1;
      load_bytes = BYTES_W'((fill + FILL_W'(7)) >> 3);
      load_last  = 1'b1;
      base_acc   = '0;
      base_fill  = '0;
      state_nxt  = RUN;
    end
    acc_nxt  = base_acc;
    fill_nxt = base_fill;
    if (accept) begin
      acc_nxt  = base_acc | (code_top >> base_fill);
      fill_nxt = base_fill + FILL_W'(in_len);
      if (in_flush) state_nxt = FLUSH;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      acc   <= '0;
      fill  <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      fill  <= fill_nxt;
    end
  end

  bit_packer_out_reg #(
    .DATA_W  (OUT_W),
    .BYTES_W (BYTES_W)
  ) u_out_reg (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .load_data  (load_data),
    .load_bytes (load_bytes),
    .load_last  (load_last),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_bytes  (out_bytes),
    .out_last   (out_last),
    .free       (out_free)
  );

endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer (OUT_W=32, MAX_CODE_W=32): vector table plus stall and reset sequences.
module tb_bit_packer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_flush;
  logic [31:0] in_val;
  logic [5:0]  in_len;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic [6:0]  fill_level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  b;
    logic        l;
  } word_t;

  typedef struct {
    logic [31:0] val;
    logic [5:0]  len;
    logic        flush;
    bit          has;
    logic [31:0] ed;
    logic [2:0]  eb;
    logic        el;
  } vec_t;

  word_t sb[$];
  vec_t  tbl[18];

  bit_packer #(.OUT_W(32), .MAX_CODE_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_val     (in_val),
    .in_len     (in_len),
    .in_flush   (in_flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_bytes  (out_bytes),
    .out_last   (out_last),
    .fill_level (fill_level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // A word present with out_ready at the falling edge transfers on the next rising edge.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h with nothing expected", out_data);
      end else begin
        word_t e;
        e = sb.pop_front();
        chk("word_data", out_data, e.d);
        chk("word_bytes", 32'(out_bytes), 32'(e.b));
        chk("word_last", 32'(out_last), 32'(e.l));
      end
    end
  end

  task automatic send(input logic [31:0] v, input logic [5:0] l, input logic f,
                      input bit has, input logic [31:0] ed, input logic [2:0] eb, input logic el);
    int n = 0;
    in_val   = v;
    in_len   = l;
    in_flush = f;
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clock);
      if (has) sb.push_back('{d: ed, b: eb, l: el});
    end
    #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h5,        6'd3,  1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[1]  = '{32'h6,        6'd5,  1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[2]  = '{32'h0,        6'd0,  1'b1, 1'b1, 32'hA6000000, 3'd1, 1'b1};
    tbl[3]  = '{32'hFF,       6'd8,  1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[4]  = '{32'h00,       6'd8,  1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[5]  = '{32'hAA,       6'd8,  1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[6]  = '{32'h55,       6'd8,  1'b0, 1'b1, 32'hFF00AA55, 3'd4, 1'b0};
    tbl[7]  = '{32'h0,        6'd7,  1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[8]  = '{32'hFFFFFFFF, 6'd32, 1'b0, 1'b1, 32'h01FFFFFF, 3'd4, 1'b0};
    tbl[9]  = '{32'h0,        6'd0,  1'b1, 1'b1, 32'hFE000000, 3'd1, 1'b1};
    tbl[10] = '{32'hFFFFFFFF, 6'd4,  1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[11] = '{32'h0,        6'd0,  1'b1, 1'b1, 32'hF0000000, 3'd1, 1'b1};
    tbl[12] = '{32'h12345678, 6'd32, 1'b1, 1'b1, 32'h12345678, 3'd4, 1'b1};
    tbl[13] = '{32'h0,        6'd0,  1'b1, 1'b1, 32'h00000000, 3'd0, 1'b1};
    tbl[14] = '{32'h3,        6'd2,  1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[15] = '{32'hFFFF,     6'd0,  1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[16] = '{32'h1,        6'd1,  1'b0, 1'b0, 32'h0,        3'd0, 1'b0};
    tbl[17] = '{32'hABC,      6'd12, 1'b1, 1'b1, 32'hF5780000, 3'd2, 1'b1};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_val    = '0;
    in_len    = '0;
    in_flush  = 1'b0;
    out_ready = 1'b1;
    #7;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_bytes", 32'(out_bytes), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    foreach (tbl[i])
      send(tbl[i].val, tbl[i].len, tbl[i].flush, tbl[i].has, tbl[i].ed, tbl[i].eb, tbl[i].el);

    // Word latency: a full accumulator emits on the following edge.
    repeat (3) @(posedge clock);
    #1;
    send(32'hDEADBEEF, 6'd32, 1'b0, 1'b1, 32'hDEADBEEF, 3'd4, 1'b0);
    chk("lat_fill", 32'(fill_level), 32'd32);
    chk("lat_valid_early", 32'(out_valid), 32'd0);
    @(posedge clock);
    #1;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", out_data, 32'hDEADBEEF);

    // Stall: single-bit beats with the consumer blocked.
    @(posedge clock);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 64; i++)
      send(32'h1, 6'd1, 1'b0, (i == 31) || (i == 63), 32'hFFFFFFFF, 3'd4, 1'b0);
    @(posedge clock);
    #1;
    chk("stall_fill", 32'(fill_level), 32'd32);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, 32'hFFFFFFFF);
    end
    out_ready = 1'b1;
    send(32'h0, 6'd0, 1'b1, 1'b1, 32'h00000000, 3'd0, 1'b1);

    // Reset while stuck in FLUSH with a pending word; discarded words are never expected.
    repeat (3) @(posedge clock);
    #1 out_ready = 1'b0;
    send(32'hFFFFFFFF, 6'd32, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0);
    send(32'hF, 6'd4, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_fill", 32'(fill_level), 32'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_fill", 32'(fill_level), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    send(32'h5, 6'd3, 1'b1, 1'b1, 32'hA0000000, 3'd1, 1'b1);

    for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clock);
    repeat (2) @(posedge clock);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
